// File: rtl/dual_port_mem_arbiter.sv
// Shares one single-ported synchronous RAM between the CPU instruction and data ports.
// Per-cycle grant, no stalls; responses are routed by a latency-matched owner pipeline.
module dual_port_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int RR_MODE     = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic [DATA_W/8-1:0] inst_wen,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [DATA_W-1:0]   inst_wdata,
    output logic                inst_gnt,
    output logic                inst_rvalid,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_gnt,
    output logic                data_rvalid,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int LAST = MEM_LATENCY - 1;

    // last_q: 1 = data port owned the most recent grant
    logic                   last_q, last_d;
    logic [MEM_LATENCY-1:0] vld_q, vld_d;
    logic [MEM_LATENCY-1:0] own_q, own_d;

    always_comb begin
        inst_gnt = 1'b0;
        data_gnt = 1'b0;
        if (!reset) begin
            if (data_req && (!inst_req || RR_MODE == 0 || !last_q)) begin
                data_gnt = 1'b1;
            end else if (inst_req) begin
                inst_gnt = 1'b1;
            end
        end
    end

    assign mem_en = inst_gnt | data_gnt;

    always_comb begin
        mem_wen   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (data_gnt) begin
            mem_wen   = data_wen;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (inst_gnt) begin
            mem_wen   = inst_wen;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end
    end

    always_comb begin
        last_d = last_q;
        if (data_gnt) begin
            last_d = 1'b1;
        end else if (inst_gnt) begin
            last_d = 1'b0;
        end
        vld_d    = vld_q;
        own_d    = own_q;
        vld_d[0] = mem_en;
        own_d[0] = data_gnt;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b0;
            vld_q  <= '0;
            own_q  <= '0;
        end else begin
            last_q <= last_d;
            vld_q  <= vld_d;
            own_q  <= own_d;
        end
    end

    assign inst_rvalid = vld_q[LAST] & ~own_q[LAST];
    assign data_rvalid = vld_q[LAST] & own_q[LAST];
    assign inst_rdata  = mem_rdata;
    assign data_rdata  = mem_rdata;

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// Three arbiter configurations driven in lockstep, each with its own RAM model,
// checked against a per-cycle transaction-level reference model.
module tb_dual_port_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req   [3];
    logic [3:0]  inst_wen   [3];
    logic [31:0] inst_addr  [3];
    logic [31:0] inst_wdata [3];
    logic        inst_gnt   [3];
    logic        inst_rvalid[3];
    logic [31:0] inst_rdata [3];
    logic        data_req   [3];
    logic [3:0]  data_wen   [3];
    logic [31:0] data_addr  [3];
    logic [31:0] data_wdata [3];
    logic        data_gnt   [3];
    logic        data_rvalid[3];
    logic [31:0] data_rdata [3];
    logic        mem_en     [3];
    logic [3:0]  mem_wen    [3];
    logic [31:0] mem_addr   [3];
    logic [31:0] mem_wdata  [3];
    logic [31:0] mem_rdata  [3];

    int checks   = 0;
    int failures = 0;
    int cnum     = 0;

    logic        ev [3][8];
    logic        eo [3][8];
    logic        er [3][8];
    logic [31:0] ed [3][8];
    logic        lo [3];
    logic [31:0] sh [3][1024];

    always #5 clk = ~clk;

    function automatic logic [31:0] ival(int g, int i);
        return 32'(32'hC0DE0000 + g * 4096 + i);
    endfunction

    function automatic int lat_of(int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        logic [31:0] ram  [1024];
        logic [31:0] pipe [L];

        dual_port_mem_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L),
            .RR_MODE((g == 0) ? 0 : 1)
        ) u_dut (
            .clk(clk), .reset(reset),
            .inst_req(inst_req[g]), .inst_wen(inst_wen[g]),
            .inst_addr(inst_addr[g]), .inst_wdata(inst_wdata[g]),
            .inst_gnt(inst_gnt[g]), .inst_rvalid(inst_rvalid[g]),
            .inst_rdata(inst_rdata[g]),
            .data_req(data_req[g]), .data_wen(data_wen[g]),
            .data_addr(data_addr[g]), .data_wdata(data_wdata[g]),
            .data_gnt(data_gnt[g]), .data_rvalid(data_rvalid[g]),
            .data_rdata(data_rdata[g]),
            .mem_en(mem_en[g]), .mem_wen(mem_wen[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g])
        );

        initial begin
            for (int i = 0; i < 1024; i++) ram[i] <= ival(g, i);
        end

        always @(posedge clk) begin
            if (mem_en[g]) begin
                pipe[0] <= ram[mem_addr[g][11:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_wen[g][b])
                        ram[mem_addr[g][11:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end else begin
                pipe[0] <= 32'h0;
            end
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end

        assign mem_rdata[g] = pipe[L-1];
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic ir, logic [3:0] iw, logic [31:0] ia,
                         logic [31:0] iwd, logic dr, logic [3:0] dw,
                         logic [31:0] da, logic [31:0] dwd);
        for (int g = 0; g < 3; g++) begin
            inst_req[g] = ir; inst_wen[g] = iw;
            inst_addr[g] = ia; inst_wdata[g] = iwd;
            data_req[g] = dr; data_wen[g] = dw;
            data_addr[g] = da; data_wdata[g] = dwd;
        end
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Model: at the negedge, check responses due now, then predict this cycle's grant.
    task automatic chk();
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            int s, ns;
            logic ig, dg;
            logic [31:0] a, wd;
            logic [3:0] we;
            logic [9:0] wi;
            s = cnum % 8;
            check($sformatf("u%0d_inst_rvalid", g), {31'b0, inst_rvalid[g]},
                  {31'b0, ev[g][s] && !eo[g][s]});
            check($sformatf("u%0d_data_rvalid", g), {31'b0, data_rvalid[g]},
                  {31'b0, ev[g][s] && eo[g][s]});
            if (ev[g][s] && er[g][s])
                check($sformatf("u%0d_rdata", g),
                      eo[g][s] ? data_rdata[g] : inst_rdata[g], ed[g][s]);
            ev[g][s] = 1'b0;
            ig = 1'b0;
            dg = 1'b0;
            if (!reset) begin
                if (inst_req[g] && data_req[g]) begin
                    if (g == 0 || lo[g] == 1'b0) dg = 1'b1;
                    else ig = 1'b1;
                end else begin
                    ig = inst_req[g];
                    dg = data_req[g];
                end
            end
            a  = dg ? data_addr[g]  : (ig ? inst_addr[g]  : 32'h0);
            wd = dg ? data_wdata[g] : (ig ? inst_wdata[g] : 32'h0);
            we = dg ? data_wen[g]   : (ig ? inst_wen[g]   : 4'h0);
            check($sformatf("u%0d_inst_gnt", g), {31'b0, inst_gnt[g]}, {31'b0, ig});
            check($sformatf("u%0d_data_gnt", g), {31'b0, data_gnt[g]}, {31'b0, dg});
            check($sformatf("u%0d_mem_en", g), {31'b0, mem_en[g]}, {31'b0, ig | dg});
            check($sformatf("u%0d_mem_addr", g), mem_addr[g], a);
            check($sformatf("u%0d_mem_wdata", g), mem_wdata[g], wd);
            check($sformatf("u%0d_mem_wen", g), {28'b0, mem_wen[g]}, {28'b0, we});
            if (reset) begin
                for (int k = 0; k < 8; k++) ev[g][k] = 1'b0;
                lo[g] = 1'b0;
            end else if (ig || dg) begin
                ns = (cnum + lat_of(g)) % 8;
                wi = a[11:2];
                ev[g][ns] = 1'b1;
                eo[g][ns] = dg;
                er[g][ns] = (we == 4'h0);
                ed[g][ns] = sh[g][wi];
                for (int b = 0; b < 4; b++)
                    if (we[b]) sh[g][wi][8*b +: 8] = wd[8*b +: 8];
                lo[g] = dg;
            end
        end
        cnum++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        chk();
        step();
    endtask

    initial begin
        logic [31:0] ra, rb;
        for (int g = 0; g < 3; g++) begin
            lo[g] = 1'b0;
            for (int k = 0; k < 8; k++) begin
                ev[g][k] = 1'b0; eo[g][k] = 1'b0;
                er[g][k] = 1'b0; ed[g][k] = 32'h0;
            end
            for (int i = 0; i < 1024; i++) sh[g][i] = ival(g, i);
        end
        reset = 1'b1;
        idle();
        step();
        step();
        tick();
        reset = 1'b0;

        // single instruction read
        drive(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk();
        check("p1_inst_gnt", {31'b0, inst_gnt[0]}, 32'd1);
        check("p1_mem_addr", mem_addr[0], 32'h100);
        step();
        idle();
        chk();
        check("p1_inst_rvalid", {31'b0, inst_rvalid[0]}, 32'd1);
        check("p1_inst_rdata", inst_rdata[0], ival(0, 32'h40));
        step();

        // fixed priority conflict
        drive(1'b1, 4'h0, 32'h000, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
        for (int k = 0; k < 3; k++) begin
            chk();
            check("p2_data_gnt", {31'b0, data_gnt[0]}, 32'd1);
            check("p2_inst_gnt", {31'b0, inst_gnt[0]}, 32'd0);
            step();
        end
        idle();
        for (int k = 0; k < 5; k++) tick();

        // round-robin alternation after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 4'h0, 32'h008, 32'h0, 1'b1, 4'h0, 32'h20C, 32'h0);
        for (int k = 0; k < 4; k++) begin
            chk();
            check("p3_data_gnt", {31'b0, data_gnt[1]}, {31'b0, k % 2 == 0});
            check("p3_inst_gnt", {31'b0, inst_gnt[1]}, {31'b0, k % 2 == 1});
            step();
        end
        idle();
        for (int k = 0; k < 5; k++) tick();

        // write then read back, latency 3
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0);
        tick();
        idle();
        for (int i = 0; i < 6; i++) begin
            chk();
            if (i == 1)
                check("p4_wr_ack", {31'b0, data_rvalid[1]}, 32'd1);
            if (i == 2) begin
                check("p4_rd_valid", {31'b0, data_rvalid[1]}, 32'd1);
                check("p4_rd_data", data_rdata[1], 32'hDEADBEEF);
            end
            step();
        end

        // in-flight reads discarded by reset, latency 4
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h14, 32'h0);
        tick();
        reset = 1'b1;
        chk();
        check("p5_gnt_in_reset", {31'b0, data_gnt[2]}, 32'd0);
        check("p5_en_in_reset", {31'b0, mem_en[2]}, 32'd0);
        step();
        reset = 1'b0;
        idle();
        for (int i = 0; i < 6; i++) begin
            chk();
            check("p5_no_data_rvalid", {31'b0, data_rvalid[2]}, 32'd0);
            check("p5_no_inst_rvalid", {31'b0, inst_rvalid[2]}, 32'd0);
            step();
        end

        // alternating single requesters
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0)
                drive(1'b1, 4'h0, 32'(k * 4), 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
            else
                drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'(k * 4), 32'h0);
            chk();
            for (int g = 0; g < 3; g++) begin
                check("p6_inst_gnt", {31'b0, inst_gnt[g]}, {31'b0, k % 2 == 0});
                check("p6_data_gnt", {31'b0, data_gnt[g]}, {31'b0, k % 2 == 1});
            end
            step();
        end
        idle();
        for (int k = 0; k < 5; k++) tick();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            ra = $urandom & 32'hFFFFF03C;
            rb = $urandom & 32'hFFFFF03C;
            drive($urandom_range(0, 1) == 1,
                  ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                  ra, $urandom,
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                  rb, $urandom);
            reset = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 1'b0;
        idle();
        for (int k = 0; k < 6; k++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_port_mem_arbiter.md
Name: dual_port_mem_arbiter

Overview:
Parametrised successor to the SoC memory hookup. It lets the CPU instruction port and data port share one single-ported synchronous RAM.
- Per-cycle arbitration between the two ports.
- Pipelined issue: up to one grant per cycle.
- Response routing through a latency-matched owner pipeline.
- Sits between the CPU sram ports and a unified RAM, all in one clock domain.

Parameters:
ADDR_W, 32, address width of both ports and the RAM
DATA_W, 32, data width; a multiple of 8
MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal range 1..4
RR_MODE, 0, 0 = fixed priority (data port wins); 1 = round-robin

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
inst_req  input  1  instruction port request
inst_wen  input  DATA_W/8  instruction port byte write enables (0 = read)
inst_addr  input  ADDR_W  instruction port address
inst_wdata  input  DATA_W  instruction port write data
inst_gnt  output  1  instruction request accepted this cycle
inst_rvalid  output  1  instruction response pulse
inst_rdata  output  DATA_W  instruction read data, qualified by inst_rvalid
data_req, data_wen, data_addr, data_wdata, data_gnt, data_rvalid, data_rdata: same as the instruction port, for the data port
mem_en  output  1  RAM enable
mem_wen  output  DATA_W/8  RAM byte write enables
mem_addr  output  ADDR_W  RAM address
mem_wdata  output  DATA_W  RAM write data
mem_rdata  input  DATA_W  RAM read data, valid MEM_LATENCY cycles after mem_en

Behaviour:
Arbitration:
- Combinational within the cycle.
- At most one of inst_gnt / data_gnt is high, and only if its req is high.
- mem_en = inst_gnt | data_gnt.
- mem_wen/addr/wdata are muxed from the granted port; when idle they are 0.
- A non-granted request is not latched. The requester holds req and its fields until gnt.

Fixed mode (RR_MODE=0):
- Data port wins every conflict.
- Inst can starve; that is accepted behaviour.

Round-robin mode (RR_MODE=1):
- Register last_owner, reset value = inst.
- On a conflict, grant the port that is not last_owner.
- last_owner updates only on a grant.
- A single requester is always granted.

Owner pipeline:
- Shift register of MEM_LATENCY stages, each {valid, owner}.
- Stage 0 is loaded with {mem_en, owner} each cycle; all stages advance every cycle with no stall.
- Output stage valid → the owner's rvalid is a 1-cycle pulse, exactly MEM_LATENCY cycles after the grant.
- Writes also produce an rvalid pulse (write acknowledge); rdata is then don't-care.
- inst_rdata and data_rdata both wire directly to mem_rdata. Only rvalid qualifies them.

Timing and reset:
- Throughput is 1 transaction per cycle; back-to-back grants to the same or alternating ports are legal.
- Reset (synchronous, active-high):
  - all pipeline valids → 0; last_owner → inst.
  - rvalid outputs are 0 in the cycle after reset is sampled.
  - In-flight responses are discarded.
- gnt and mem_en are forced 0 while reset is high.
- Simultaneous events: a grant and an rvalid on the same port in one cycle are independent and both legal.

Test Plan:
1. Reset, then inst_req=1, inst_addr=0x100, wen=0, MEM_LATENCY=1 → inst_gnt=1 and mem_addr=0x100 that cycle; inst_rvalid=1 next cycle with inst_rdata = RAM[0x100].
2. RR_MODE=0, both ports request for 3 cycles (data_addr=0x200, inst_addr=0x000) → data_gnt=1 ×3, inst_gnt=0 ×3, three data_rvalid pulses.
3. RR_MODE=1, both ports request continuously for 4 cycles → grants alternate data, inst, data, inst (last_owner=inst after reset); rvalid pattern matches, delayed by MEM_LATENCY.
4. MEM_LATENCY=3, data write wen=0xF, addr=0x40, wdata=0xDEADBEEF, then a read of 0x40 → write ack pulse at grant+3; read returns 0xDEADBEEF at its grant+3.
5. MEM_LATENCY=4, issue 2 reads, assert reset 1 cycle later → no rvalid pulses at any time after reset; gnt=0 during reset.
6. Alternating single requests inst/data every cycle for 8 cycles → every request is granted in the same cycle, with 8 rvalid pulses routed to the correct port in order.
